// File: rtl/sync_timing_detector.sv
// sync_timing_detector
// Measures a sync pulse train that is already in the Clk domain. It reports
// the period (cycles between pulse starts) and the active width of each
// pulse, and raises Locked once several consecutive measurements agree.
// A counter that saturates aborts the measurement with a one-cycle Error
// strobe, and the detector then waits for a fresh pulse.

module sync_timing_detector #(
    parameter int   PULSE_WIDTH   = 8,
    parameter int   REZ_MAX_WIDTH = 12,
    parameter logic SYNC_POL      = 1'b1,
    parameter int   LOCK_COUNT    = 3
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Sync_in,
    output logic [REZ_MAX_WIDTH-1:0] Period,
    output logic [PULSE_WIDTH-1:0]   Pulse_width,
    output logic                     Meas_valid,
    output logic                     Locked,
    output logic                     Error
);

    localparam logic [REZ_MAX_WIDTH-1:0] PERIOD_ONE = REZ_MAX_WIDTH'(1);
    localparam logic [REZ_MAX_WIDTH-1:0] PERIOD_MAX = '1;
    localparam logic [PULSE_WIDTH-1:0]   WIDTH_ONE  = PULSE_WIDTH'(1);
    localparam logic [PULSE_WIDTH-1:0]   WIDTH_MAX  = '1;
    localparam logic [3:0]               LOCK_CNT   = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     sync_q;
    logic [REZ_MAX_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [PULSE_WIDTH-1:0]   width_cnt_q, width_cnt_d;
    logic [PULSE_WIDTH-1:0]   width_meas_q, width_meas_d;
    logic [REZ_MAX_WIDTH-1:0] period_q, period_d;
    logic [PULSE_WIDTH-1:0]   pulse_width_q, pulse_width_d;
    logic                     meas_valid_q, meas_valid_d;
    logic                     error_q, error_d;
    logic                     locked_q, locked_d;
    logic [3:0]               match_cnt_q, match_cnt_d;
    // Set once a pair has been captured since reset; the first measurement
    // after reset has nothing to be compared against.
    logic                     have_prev_q, have_prev_d;

    logic start_edge;
    logic end_edge;
    logic width_full;
    logic period_full;
    logic same_pair;
    logic overflow;

    assign start_edge  = (Sync_in == SYNC_POL) && (sync_q != SYNC_POL);
    assign end_edge    = (Sync_in != SYNC_POL) && (sync_q == SYNC_POL);
    assign width_full  = (width_cnt_q == WIDTH_MAX);
    assign period_full = (period_cnt_q == PERIOD_MAX);
    // At a start edge in GAP the running counters hold the new measurement.
    assign same_pair   = have_prev_q
                         && (period_cnt_q == period_q)
                         && (width_meas_q == pulse_width_q);

    // Next-state, counter and measurement logic of the measuring FSM.
    always_comb begin
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        width_cnt_d   = width_cnt_q;
        width_meas_d  = width_meas_q;
        period_d      = period_q;
        pulse_width_d = pulse_width_q;
        meas_valid_d  = 1'b0;
        error_d       = 1'b0;
        locked_d      = locked_q;
        match_cnt_d   = match_cnt_q;
        have_prev_d   = have_prev_q;
        overflow      = 1'b0;

        case (state_q)
            IDLE: begin
                // Arm on a start edge; there is no earlier start to measure from.
                if (start_edge) begin
                    period_cnt_d = PERIOD_ONE;
                    width_cnt_d  = WIDTH_ONE;
                    state_d      = PULSE;
                end
            end

            PULSE: begin
                // Staying in PULSE without an end edge means Sync_in is still
                // active, so a full width counter cannot count this cycle.
                if ((!end_edge && width_full) || period_full) begin
                    overflow = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + PERIOD_ONE;
                    width_cnt_d  = width_cnt_q + WIDTH_ONE;
                    if (end_edge) begin
                        width_meas_d = width_cnt_q;
                        state_d      = GAP;
                    end
                end
            end

            GAP: begin
                // A start edge wins over a full period counter: a period of
                // exactly all-ones is still a valid measurement.
                if (start_edge) begin
                    period_d      = period_cnt_q;
                    pulse_width_d = width_meas_q;
                    meas_valid_d  = 1'b1;
                    have_prev_d   = 1'b1;
                    if (same_pair) begin
                        match_cnt_d = (match_cnt_q >= LOCK_CNT) ? LOCK_CNT
                                                                : match_cnt_q + 4'd1;
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                    locked_d     = (match_cnt_d == LOCK_CNT);
                    period_cnt_d = PERIOD_ONE;
                    width_cnt_d  = WIDTH_ONE;
                    state_d      = PULSE;
                end else if (period_full) begin
                    overflow = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + PERIOD_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Overflow abandons the measurement but keeps the last captured pair.
        if (overflow) begin
            error_d     = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = 4'd0;
            state_d     = IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= IDLE;
            sync_q        <= ~SYNC_POL;
            period_cnt_q  <= '0;
            width_cnt_q   <= '0;
            width_meas_q  <= '0;
            period_q      <= '0;
            pulse_width_q <= '0;
            meas_valid_q  <= 1'b0;
            error_q       <= 1'b0;
            locked_q      <= 1'b0;
            match_cnt_q   <= 4'd0;
            have_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= Sync_in;
            period_cnt_q  <= period_cnt_d;
            width_cnt_q   <= width_cnt_d;
            width_meas_q  <= width_meas_d;
            period_q      <= period_d;
            pulse_width_q <= pulse_width_d;
            meas_valid_q  <= meas_valid_d;
            error_q       <= error_d;
            locked_q      <= locked_d;
            match_cnt_q   <= match_cnt_d;
            have_prev_q   <= have_prev_d;
        end
    end

    assign Period      = period_q;
    assign Pulse_width = pulse_width_q;
    assign Meas_valid  = meas_valid_q;
    assign Locked      = locked_q;
    assign Error       = error_q;

endmodule

// File: tb/tb_sync_timing_detector.sv
// tb_sync_timing_detector
// Drives directed and random sync pulse trains. A timestamp-based reference
// model predicts every Meas_valid (period, width, lock) and every Error
// strobe into queues; a separate monitor pops and compares them when the
// DUT presents its strobes.

module tb_sync_timing_detector;

    localparam int   PW   = 8;
    localparam int   RW   = 12;
    localparam logic POL  = 1'b1;
    localparam int   LC   = 3;
    localparam int   WMAX = (1 << PW) - 1;
    localparam int   PMAX = (1 << RW) - 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          sync_in = ~POL;
    logic [RW-1:0] period;
    logic [PW-1:0] pulse_width;
    logic          meas_valid;
    logic          locked;
    logic          error;

    sync_timing_detector #(
        .PULSE_WIDTH  (PW),
        .REZ_MAX_WIDTH(RW),
        .SYNC_POL     (POL),
        .LOCK_COUNT   (LC)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Sync_in    (sync_in),
        .Period     (period),
        .Pulse_width(pulse_width),
        .Meas_valid (meas_valid),
        .Locked     (locked),
        .Error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int period;
        int width;
        bit locked;
    } meas_t;

    meas_t meas_q[$];
    int    err_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: remembers when the current pulse started and ended,
    // derives period and width by subtraction, and tracks the lock history.
    bit m_prev_act;
    bit m_armed;
    bit m_in_pulse;
    bit m_have_prev;
    int m_start;
    int m_end;
    int m_prev_p;
    int m_prev_w;
    int m_matches;

    function automatic void model_step(bit act, bit r, int c);
        bit    st;
        bit    en;
        bit    ovf;
        int    p;
        int    w;
        meas_t m;
        if (!r) begin
            m_prev_act  = 1'b0;
            m_armed     = 1'b0;
            m_in_pulse  = 1'b0;
            m_have_prev = 1'b0;
            m_matches   = 0;
            return;
        end
        st  = act && !m_prev_act;
        en  = !act && m_prev_act;
        ovf = 1'b0;
        if (!m_armed) begin
            if (st) begin
                m_armed    = 1'b1;
                m_in_pulse = 1'b1;
                m_start    = c;
            end
        end else if (m_in_pulse) begin
            if (en) begin
                m_in_pulse = 1'b0;
                m_end      = c;
            end else if ((c - m_start) >= WMAX || (c - m_start) >= PMAX) begin
                ovf = 1'b1;
            end
        end else begin
            if (st) begin
                p = c - m_start;
                w = m_end - m_start;
                if (m_have_prev && p == m_prev_p && w == m_prev_w)
                    m_matches = (m_matches < LC) ? m_matches + 1 : LC;
                else
                    m_matches = 0;
                m_have_prev = 1'b1;
                m_prev_p    = p;
                m_prev_w    = w;
                m.cyc    = c;
                m.period = p;
                m.width  = w;
                m.locked = (m_matches == LC);
                meas_q.push_back(m);
                m_start    = c;
                m_in_pulse = 1'b1;
            end else if ((c - m_start) >= PMAX) begin
                ovf = 1'b1;
            end
        end
        if (ovf) begin
            err_q.push_back(c);
            m_armed   = 1'b0;
            m_matches = 0;
        end
        m_prev_act = act;
    endfunction

    // One sample: the value set here is taken by the DUT at the next edge.
    task automatic drive(bit act, bit r);
        @(posedge clk);
        #1;
        rst     = r;
        sync_in = act ? POL : ~POL;
        model_step(act, r, cyc + 1);
    endtask

    task automatic pulse(int w, int g);
        repeat (w) drive(1'b1, 1'b1);
        repeat (g) drive(1'b0, 1'b1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_width"}, int'(pulse_width), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    // Monitor: compares DUT strobes against the predicted queues.
    initial begin
        meas_t m;
        int    e;
        forever begin
            @(negedge clk);
            if (meas_q.size() > 0 && meas_q[0].cyc < cyc) begin
                check("meas_missing_at", meas_q[0].cyc, cyc);
                void'(meas_q.pop_front());
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                check("error_missing_at", err_q[0], cyc);
                void'(err_q.pop_front());
            end
            if (meas_valid) begin
                check("meas_expected", int'(meas_q.size() > 0), 1);
                check("meas_error_overlap", int'(error), 0);
                if (meas_q.size() > 0) begin
                    m = meas_q.pop_front();
                    check("meas_cycle", cyc, m.cyc);
                    check("period", int'(period), m.period);
                    check("pulse_width", int'(pulse_width), m.width);
                    check("locked", int'(locked), int'(m.locked));
                    $display("meas cyc=%0d period=%0d width=%0d locked=%0d", cyc, period, pulse_width, locked);
                end
            end
            if (error) begin
                check("error_expected", int'(err_q.size() > 0), 1);
                check("locked_after_error", int'(locked), 0);
                if (err_q.size() > 0) begin
                    e = err_q.pop_front();
                    check("error_cycle", cyc, e);
                    $display("error cyc=%0d", cyc);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int w;
        int g;
        int n;

        repeat (3) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        check_all_zero("reset");

        // 8/1 train: lock on the 4th measurement
        repeat (10) pulse(1, 7);
        // switch to 800/94: lock drops then returns
        repeat (6) pulse(94, 706);
        // one 801 period breaks lock, two measurements mismatch
        pulse(94, 707);
        repeat (6) pulse(94, 706);

        // random trains with occasional jitter
        repeat (12) begin
            w = $urandom_range(1, 20);
            g = $urandom_range(1, 40);
            n = $urandom_range(1, 6);
            repeat (n) pulse(w, g);
            if ($urandom_range(0, 3) == 0) pulse(w, g + 1);
        end

        // boundaries: widest pulse, shortest period, longest period
        repeat (3) pulse(WMAX, 10);
        repeat (6) pulse(1, 1);
        repeat (2) pulse(1, PMAX - 1);
        // sync held inactive: period overflow, then recovery
        pulse(1, 4200);
        repeat (5) pulse(5, 10);
        // sync held active: width overflow, then recovery
        pulse(300, 10);
        repeat (6) pulse(3, 7);

        // reset for one cycle in mid-pulse while locked
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        check_all_zero("midreset");
        pulse(2, 7);
        repeat (5) pulse(3, 7);

        repeat (5) drive(1'b0, 1'b1);
        check("meas_leftover", meas_q.size(), 0);
        check("error_leftover", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
